// File: rtl/dac_multi_channel_writer_if.sv
// dac_multi_channel_writer_if
//   Write-request handshake into the DAC write engine.
//   master : requester (drives s_valid, s_ch, s_data; samples s_ready)
//   slave  : write engine (samples the request; drives s_ready)
interface dac_multi_channel_writer_if #(
  parameter int DATA_W = 14,
  parameter int CH_W   = 2
);
  logic              s_valid;
  logic              s_ready;
  logic [CH_W-1:0]   s_ch;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, s_ch, s_data, input s_ready);
  modport slave  (input s_valid, s_ch, s_data, output s_ready);
endinterface

// File: rtl/dac_multi_channel_writer.sv
// dac_multi_channel_writer
//   Write engine for NUM_CH parallel DACs sharing one data bus and one WR
//   strobe, each with its own active-low chip select. Every accepted request
//   runs a setup -> WR pulse -> settle sequence and reports completion.
//
//   Optional feature: define DAC_SKIP_DUPLICATE_EN to keep a per-channel
//   shadow of the last written value and skip writes that would not change it.
//
// Ports
//   clk, reset   system clock, synchronous active-high reset
//   req          request handshake (slave side): s_valid/s_ready/s_ch/s_data
//   dac_out      shared parallel data bus (holds last written value)
//   dac_cs_n     per-DAC chip select, active low
//   wr           write strobe, DAC latches on its rising edge
//   busy         FSM not IDLE
//   done         one-cycle completion pulse, done_ch/done_skip valid with it
//   err          one-cycle pulse: request for a nonexistent channel dropped
//
// state  | meaning
// IDLE   | s_ready high, waiting for a request
// SETUP  | data and CS driven, waiting before the WR rise
// STROBE | WR high
// SETTLE | WR and CS released, waiting for the DAC output to settle
module dac_multi_channel_writer #(
  parameter  int DATA_W        = 14,
  parameter  int NUM_CH        = 4,
  parameter  int SETUP_CYCLES  = 1,
  parameter  int WR_CYCLES     = 1,
  parameter  int SETTLE_CYCLES = 10,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  dac_multi_channel_writer_if.slave  req,
  output logic [DATA_W-1:0]          dac_out,
  output logic [NUM_CH-1:0]          dac_cs_n,
  output logic                       wr,
  output logic                       busy,
  output logic                       done,
  output logic [CH_W-1:0]            done_ch,
  output logic                       done_skip,
  output logic                       err
);

  localparam int MAX_A     = (SETUP_CYCLES > WR_CYCLES) ? SETUP_CYCLES : WR_CYCLES;
  localparam int MAX_CYC   = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int CNT_W     = $clog2(MAX_CYC + 1);
  localparam int SETTLE_LD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, SETTLE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [DATA_W-1:0] dac_out_d;
  logic [NUM_CH-1:0] cs_n_d;
  logic              wr_d, busy_d, done_d, done_skip_d, err_d;
  logic [CH_W-1:0]   done_ch_d;

  logic        acc, ch_ok, dup_hit, cnt_zero;
  logic [31:0] ch_ext;

  assign req.s_ready = (state_q == IDLE) && !reset;
  assign acc         = req.s_valid && req.s_ready;
  // Widen before comparing so non-power-of-two NUM_CH is range checked.
  assign ch_ext      = 32'(req.s_ch);
  assign ch_ok       = ch_ext < 32'(NUM_CH);
  assign cnt_zero    = (cnt_q == '0);

`ifdef DAC_SKIP_DUPLICATE_EN
  logic [DATA_W-1:0] shadow_q [NUM_CH];
  logic [NUM_CH-1:0] shadow_vld_q;

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_ext == 32'(i) && shadow_vld_q[i] && shadow_q[i] == req.s_data)
        dup_hit = 1'b1;
  end

  // Shadow captures the value the DAC actually latches, i.e. at the WR rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_vld_q <= '0;
    end else if (state_q == SETUP && cnt_zero) begin
      for (int i = 0; i < NUM_CH; i++)
        if (32'(ch_q) == 32'(i)) begin
          shadow_q[i]     <= dac_out;
          shadow_vld_q[i] <= 1'b1;
        end
    end
  end
`else
  assign dup_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ch_q      <= '0;
      dac_out   <= '0;
      dac_cs_n  <= '1;
      wr        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_ch   <= '0;
      done_skip <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      dac_out   <= dac_out_d;
      dac_cs_n  <= cs_n_d;
      wr        <= wr_d;
      busy      <= busy_d;
      done      <= done_d;
      done_ch   <= done_ch_d;
      done_skip <= done_skip_d;
      err       <= err_d;
    end
  end

  // Down-counter reloads with (length-1) on each state entry; leave on zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:
        if (acc && ch_ok && !dup_hit) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYCLES - 1);
        end
      SETUP:
        if (cnt_zero) begin
          state_d = STROBE;
          cnt_d   = CNT_W'(WR_CYCLES - 1);
        end else cnt_d = cnt_q - CNT_W'(1);
      STROBE:
        if (cnt_zero) begin
          state_d = (SETTLE_CYCLES == 0) ? IDLE : SETTLE;
          cnt_d   = CNT_W'(SETTLE_LD);
        end else cnt_d = cnt_q - CNT_W'(1);
      SETTLE:
        if (cnt_zero) state_d = IDLE;
        else          cnt_d   = cnt_q - CNT_W'(1);
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    dac_out_d   = dac_out;
    cs_n_d      = dac_cs_n;
    wr_d        = wr;
    ch_d        = ch_q;
    done_d      = 1'b0;
    done_ch_d   = done_ch;
    done_skip_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE:
        if (acc) begin
          if (!ch_ok) begin
            err_d = 1'b1;
          end else if (dup_hit) begin
            done_d      = 1'b1;
            done_skip_d = 1'b1;
            done_ch_d   = req.s_ch;
          end else begin
            dac_out_d = req.s_data;
            ch_d      = req.s_ch;
            for (int i = 0; i < NUM_CH; i++)
              cs_n_d[i] = (ch_ext != 32'(i));
          end
        end
      SETUP:
        if (cnt_zero) wr_d = 1'b1;
      STROBE:
        if (cnt_zero) begin
          wr_d   = 1'b0;
          cs_n_d = '1;
          if (SETTLE_CYCLES == 0) begin
            done_d    = 1'b1;
            done_ch_d = ch_q;
          end
        end
      SETTLE:
        if (cnt_zero) begin
          done_d    = 1'b1;
          done_ch_d = ch_q;
        end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule
